// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) that pushes bytes into a
// FIFO drained over valid/ready, with rts flow control derived from FIFO occupancy.
module uart_rx_fifo #(
    parameter int SYMBOL_EDGE_TIME = 1085,
    parameter int FIFO_DEPTH       = 8,
    parameter int RTS_MARGIN       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       rts,
    output logic       frame_error,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SYMBOL_EDGE_TIME / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    logic             rx_meta_q, rx_s_q, rx_prev_q;
    state_t           state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic             frame_error_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_error_q;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d, count;
    logic          full, pop, push_ok, overrun_d, rts_d;
    logic          valid_q, rts_q, overrun_q;
    logic [7:0]    dout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Frame decoder: every sample is taken on the cycle that closes its count window.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q      <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s_q && rx_prev_q) begin
                        clk_cnt_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (clk_cnt_q == CNT_HALF) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt_q == CNT_FULL) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt_q == CNT_FULL) begin
                        clk_cnt_q <= '0;
                        par_bad_q <= ^{rx_s_q, shift_q};
                        state_q   <= STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt_q == CNT_FULL) begin
                        clk_cnt_q     <= '0;
                        frame_error_q <= !rx_s_q;
                        state_q       <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        parity_error_q <= par_bad_q;
                        push_q         <= rx_s_q && !par_bad_q;
`else
                        push_q <= rx_s_q;
`endif
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        count     = wptr_q - rptr_q;
        full      = (count == PW'(FIFO_DEPTH));
        pop       = valid_q && data_out_ready;
        push_ok   = push_q && (!full || pop);
        overrun_d = push_q && full && !pop;
        wptr_d    = wptr_q + PW'(push_ok);
        rptr_d    = rptr_q + PW'(pop);
        rts_d     = (FIFO_DEPTH - int'(count)) > RTS_MARGIN;
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    // Head register: bypass the incoming byte when it becomes the head in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
            rts_q     <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            valid_q   <= (wptr_d != rptr_d);
            dout_q    <= (push_ok && wptr_q == rptr_d) ? shift_q : mem_q[rptr_d[AW-1:0]];
            rts_q     <= rts_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = valid_q;
    assign rts            = rts_q;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error   = parity_error_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receive path: oversamples `serial_in`, decodes 8N1 frames and pushes each received byte into an internal FIFO. Bytes are drained through a valid/ready port. Hardware flow control is driven on `rts` from FIFO occupancy. It is the receive-side counterpart of the UART transmitter and feeds the sys-array command/data ingress logic.

## Interface
- `SYMBOL_EDGE_TIME`, default 1085: clock cycles per bit (125 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 8: byte entries; power of two, ≥ 4.
- `RTS_MARGIN`, default 2: `rts` deasserts when free entries ≤ this value.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `serial_in` in 1: asynchronous line input, idle high.
- `data_out` out 8: FIFO head byte; valid only while `data_out_valid` is high.
- `data_out_valid` out 1: FIFO non-empty.
- `data_out_ready` in 1: consumer accepts the head byte when it is high and `data_out_valid` is high.
- `rts` out 1: high = local RX can accept data; the remote side may send.
- `frame_error` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_error` out 1: one-cycle pulse; present only with `UART_RX_PARITY_EN`.

## Operation
- Input synchronizer: `serial_in` passes through a 2-flop synchronizer. All decoding uses the synchronized value `rx_s`.
- The FSM has a cycle counter `clk_cnt` and a bit index `bit_idx` (0–7).

FSM states:
- **IDLE**: on `rx_s` = 0 with its previous value 1 (falling edge), clear `clk_cnt` and go to START.
- **START**: after `SYMBOL_EDGE_TIME/2` cycles (integer division), sample `rx_s`.
  - Sample 1: false start; return to IDLE, no flags.
  - Sample 0: go to DATA with `bit_idx` = 0.
- **DATA**: every `SYMBOL_EDGE_TIME` cycles, sample one bit into shift register position `bit_idx`. Bits arrive LSB first. After bit 7, go to STOP (or PARITY when the macro is defined).
- **STOP**: after `SYMBOL_EDGE_TIME` cycles, sample the stop bit.
  - Sample 1 with no parity error: push the byte.
  - Sample 0: pulse `frame_error` and discard the byte.
  - Either way, go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rx_s` = 1, then go to IDLE. A held break line therefore produces exactly one `frame_error`.

FIFO behaviour:
- Circular buffer with `$clog2(FIFO_DEPTH)+1`-bit read/write pointers. Full when the pointers are equal except for the MSB.
- Pop occurs on `data_out_valid && data_out_ready`.
- A push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and `overrun` pulses; existing contents are unchanged.
- A simultaneous push and pop on an empty FIFO is impossible, because `valid` is 0 when empty.
- `rts` = 1 when (`FIFO_DEPTH` − count) > `RTS_MARGIN`. It is registered and updates the cycle after a count change.
- `data_out` comes from a registered or memory read of the head entry. It must be stable while `valid` is high and not popped.

## Timing
- Reset values: `data_out_valid` = 0, `rts` = 1, `frame_error` = `overrun` = `parity_error` = 0, `data_out` = 0.
  - Reset also sets the FSM to IDLE, empties the FIFO, and fills the synchronizer with 1s.
- Let t0 be the cycle the falling edge is seen on `rx_s`, which is 2 cycles after `serial_in` falls.
- Sample points:
  - Start sample: t0 + H, where H = `SYMBOL_EDGE_TIME/2`.
  - Data bit i: t0 + H + (i+1)·`SYMBOL_EDGE_TIME`.
  - Stop: t0 + H + 9·`SYMBOL_EDGE_TIME` (10· with parity).
- The push happens in the cycle after the stop sample. `data_out_valid` rises the following cycle.
- Error pulses assert in the cycle after the offending sample.
- Reset mid-frame aborts the frame immediately. No flags are raised, and the partial byte is lost.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state between DATA and STOP samples a 9th bit, `SYMBOL_EDGE_TIME` after bit 7. Frame format is 8E1.
  - Even parity is required: XOR of the 8 data bits and the parity bit = 0.
  - On mismatch, `parity_error` pulses after the stop sample and the byte is discarded.
  - If the stop bit is also low, both `parity_error` and `frame_error` pulse in the same cycle.
- `UART_RX_PARITY_EN` undefined: 8N1 framing, no PARITY state, and the `parity_error` port is absent.

## Test plan
Use `SYMBOL_EDGE_TIME` = 16 and `FIFO_DEPTH` = 8 for all scenarios.
1. Send 0xA5 (8N1) with `data_out_ready` = 1 → `data_out_valid` pulses once with 0xA5; valid rises exactly t0 + 8 + 9·16 + 2 cycles after t0; no flags.
2. Hold `ready` = 0 and send 0x00–0x09 → `rts` falls after the 6th byte is pushed; bytes 9 and 10 each pulse `overrun`; draining then returns 0x00–0x07 in order and `rts` returns to 1.
3. Send 0x3C with the stop bit forced low, hold the line low for 40 cycles, then send 0x55 → exactly one `frame_error`; only 0x55 appears at the output.
4. Pulse `serial_in` low for 5 cycles only → false start, no output and no flags; a following 0x81 is received correctly.
5. Assert `reset` in the middle of bit 4 of 0xFF, then send 0x12 → outputs return to their reset values; only 0x12 is received.
6. With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 → byte delivered; send 0x07 with parity bit 0 → `parity_error` pulses and no byte is pushed.
